// File: rtl/pi_dpi_frame_tracker_if.sv
// DPI pin bundle plus the tracked raster outputs of pi_dpi_frame_tracker.
// The statistics members exist only when PI_FRAME_STATS_EN is defined.
interface pi_dpi_frame_tracker_if;
   logic       dpi_pclk;
   logic       dpi_hsync;
   logic       dpi_vsync;
   logic       dpi_de;
   logic [9:0] pixelX_pi;
   logic [9:0] pixelY_pi;
   logic       displayEnable_pi;
   logic       frameStart_pi;
   logic       locked;
`ifdef PI_FRAME_STATS_EN
   logic [9:0] lastFrameLines;
   logic [9:0] lastLineWidth;
   logic [9:0] hsyncPerFrame;

   modport master (
      output dpi_pclk, dpi_hsync, dpi_vsync, dpi_de,
      input  pixelX_pi, pixelY_pi, displayEnable_pi, frameStart_pi, locked,
      input  lastFrameLines, lastLineWidth, hsyncPerFrame
   );
   modport slave (
      input  dpi_pclk, dpi_hsync, dpi_vsync, dpi_de,
      output pixelX_pi, pixelY_pi, displayEnable_pi, frameStart_pi, locked,
      output lastFrameLines, lastLineWidth, hsyncPerFrame
   );
`else
   modport master (
      output dpi_pclk, dpi_hsync, dpi_vsync, dpi_de,
      input  pixelX_pi, pixelY_pi, displayEnable_pi, frameStart_pi, locked
   );
   modport slave (
      input  dpi_pclk, dpi_hsync, dpi_vsync, dpi_de,
      output pixelX_pi, pixelY_pi, displayEnable_pi, frameStart_pi, locked
   );
`endif
endinterface

// File: rtl/pi_dpi_frame_tracker.sv
// Tracks the Raspberry Pi DPI raster in the sysClk domain and reports pixel position and lock.
// Optional per-frame statistics outputs are enabled by defining PI_FRAME_STATS_EN.
module pi_dpi_frame_tracker #(
   parameter int unsigned H_ACTIVE        = 768,
   parameter int unsigned V_ACTIVE        = 576,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input logic                   sysClk,
   input logic                   nReset,
   pi_dpi_frame_tracker_if.slave dpi
);

   localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);
   localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
   localparam logic [9:0] V_LEN = 10'(V_ACTIVE);
   localparam logic [9:0] SAT   = '1;

   typedef enum logic [1:0] {SEEK, WAIT_DE, ACTIVE} trackStateT;

   logic [1:0] pclkSync, hsSync, vsSync, deSync;
   logic       pclkPrev, pclkRise;
   logic       hsSmp, vsSmp, deSmp, smpValid;
   logic       hsPrev, vsPrev, dePrev;
   logic       vsLead, hsLead, deRise, deFall;
   logic [9:0] runLen, lineCount, rawCol, runNext, lineNext;
   logic       widthBad;
   trackStateT state;
   logic [9:0] pixelX, pixelY;
   logic       dispEn, frameStart, lockedR;

   assign pclkRise = pclkSync[1] & ~pclkPrev;

   // Stage 1: synchronise, then capture the DPI levels on each pclk rise (sync polarity normalised).
   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         pclkSync <= '0;
         hsSync   <= '0;
         vsSync   <= '0;
         deSync   <= '0;
         pclkPrev <= 1'b0;
         hsSmp    <= 1'b0;
         vsSmp    <= 1'b0;
         deSmp    <= 1'b0;
         smpValid <= 1'b0;
      end else begin
         pclkSync <= {pclkSync[0], dpi.dpi_pclk};
         hsSync   <= {hsSync[0], dpi.dpi_hsync};
         vsSync   <= {vsSync[0], dpi.dpi_vsync};
         deSync   <= {deSync[0], dpi.dpi_de};
         pclkPrev <= pclkSync[1];
         smpValid <= pclkRise;
         if (pclkRise) begin
            hsSmp <= hsSync[1] ^ SYNC_ACTIVE_LOW;
            vsSmp <= vsSync[1] ^ SYNC_ACTIVE_LOW;
            deSmp <= deSync[1];
         end
      end
   end

   assign vsLead   = vsSmp & ~vsPrev;
   assign hsLead   = hsSmp & ~hsPrev;
   assign deRise   = deSmp & ~dePrev;
   assign deFall   = ~deSmp & dePrev;
   assign rawCol   = deRise ? '0 : runLen;
   assign runNext  = (runLen == SAT) ? SAT : runLen + 10'd1;
   assign lineNext = (lineCount == SAT) ? SAT : lineCount + 10'd1;

   // Stage 2: raster state machine, one step per captured sample.
   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         state      <= SEEK;
         hsPrev     <= 1'b0;
         vsPrev     <= 1'b0;
         dePrev     <= 1'b0;
         runLen     <= '0;
         lineCount  <= '0;
         widthBad   <= 1'b0;
         pixelX     <= '0;
         pixelY     <= '0;
         dispEn     <= 1'b0;
         frameStart <= 1'b0;
         lockedR    <= 1'b0;
      end else begin
         frameStart <= 1'b0;
         if (smpValid) begin
            hsPrev <= hsSmp;
            vsPrev <= vsSmp;
            dePrev <= deSmp;
            case (state)
               SEEK: begin
                  if (vsLead) state <= WAIT_DE;
               end
               WAIT_DE: begin
                  if (vsLead) begin
                     lockedR <= 1'b0;
                  end else if (deSmp) begin
                     state      <= ACTIVE;
                     runLen     <= 10'd1;
                     pixelX     <= '0;
                     pixelY     <= '0;
                     dispEn     <= 1'b1;
                     frameStart <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (vsLead) begin
                     state     <= WAIT_DE;
                     lockedR   <= (lineCount == V_LEN) && !widthBad;
                     lineCount <= '0;
                     widthBad  <= 1'b0;
                     runLen    <= '0;
                     pixelX    <= '0;
                     pixelY    <= '0;
                     dispEn    <= 1'b0;
                  end else if (deSmp) begin
                     runLen <= deRise ? 10'd1 : runNext;
                     pixelX <= (rawCol > X_MAX) ? X_MAX : rawCol;
                     if (deRise) pixelY <= (lineCount > Y_MAX) ? Y_MAX : lineCount;
                     dispEn <= (rawCol < H_LEN) && (lineCount < V_LEN);
                  end else begin
                     dispEn <= 1'b0;
                     if (deFall) begin
                        pixelX    <= '0;
                        lineCount <= lineNext;
                        if (runLen != H_LEN) widthBad <= 1'b1;
                     end
                  end
               end
               default: state <= SEEK;
            endcase
         end
      end
   end

   assign dpi.pixelX_pi        = pixelX;
   assign dpi.pixelY_pi        = pixelY;
   assign dpi.displayEnable_pi = dispEn;
   assign dpi.frameStart_pi    = frameStart;
   assign dpi.locked           = lockedR;

`ifdef PI_FRAME_STATS_EN
   logic [9:0] hsCount, lastLines, lastWidth, hsPerFrame;

   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         hsCount    <= '0;
         lastLines  <= '0;
         lastWidth  <= '0;
         hsPerFrame <= '0;
      end else if (smpValid) begin
         if (vsLead) begin
            hsCount <= {9'd0, hsLead};
            if (state != SEEK) begin
               lastLines  <= lineCount;
               hsPerFrame <= hsCount;
            end
         end else if (hsLead && hsCount != SAT) begin
            hsCount <= hsCount + 10'd1;
         end
         if (state == ACTIVE && !vsLead && deFall) lastWidth <= runLen;
      end
   end

   assign dpi.lastFrameLines = lastLines;
   assign dpi.lastLineWidth  = lastWidth;
   assign dpi.hsyncPerFrame  = hsPerFrame;
`else
   // hsync only feeds the statistics; keep the sampled edge as a named sink.
   logic unusedHsLead;
   assign unusedHsLead = hsLead;
`endif

endmodule
